// File: rtl/timer_arbiter.sv
// Round-robin shared interval timer: grants one counter to NUM_REQ requesters in turn.
// Optional TIMER_ARB_ABORT_EN: owner dropping req mid-run aborts the run without a done pulse.
`timescale 1ns/1ps
module timer_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned COUNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*COUNT_W-1:0] req_count,
    output logic [NUM_REQ-1:0]         grant,
    output logic [NUM_REQ-1:0]         done,
    output logic                       busy
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);

    typedef enum logic [0:0] {StIdle, StRunning} state_e;

    state_e             state_q, state_d;
    logic [IdxW-1:0]    owner_q, owner_d;
    logic [IdxW-1:0]    ptr_q, ptr_d;
    logic [COUNT_W-1:0] lcnt_q, lcnt_d;
    logic [COUNT_W-1:0] timer_q, timer_d;

    logic               done_hit;
    logic               abort_hit;
    logic               arb_en;
    logic               win_valid;
    logic [IdxW-1:0]    win_idx;
    logic [IdxW-1:0]    cand;
    logic [COUNT_W-1:0] win_count;
    int unsigned        ptr_int;
    int unsigned        scan_idx;

    assign ptr_int  = 32'(ptr_q);
    assign done_hit = (state_q == StRunning) && (timer_q == lcnt_q);

`ifdef TIMER_ARB_ABORT_EN
    assign abort_hit = (state_q == StRunning) && !done_hit && !req[owner_q];
`else
    assign abort_hit = 1'b0;
`endif

    // Arbitration is only permitted while idle or in the cycle a run ends.
    assign arb_en = (state_q == StIdle) || done_hit || abort_hit;

    // First requester at or after ptr, wrapping modulo NUM_REQ.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        scan_idx  = 0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan_idx = ptr_int + k;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            cand = IdxW'(scan_idx);
            if (!win_valid && req[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
        win_count = req_count[32'(win_idx) * COUNT_W +: COUNT_W];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            owner_q <= '0;
            ptr_q   <= '0;
            lcnt_q  <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            lcnt_q  <= lcnt_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        lcnt_d  = lcnt_q;
        timer_d = timer_q;
        if (arb_en) begin
            if (win_valid) begin
                state_d = StRunning;
                owner_d = win_idx;
                // A zero count still occupies one grant cycle.
                lcnt_d  = (win_count == '0) ? COUNT_W'(1) : win_count;
                timer_d = COUNT_W'(1);
                ptr_d   = (win_idx == IdxW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
            end else begin
                state_d = StIdle;
            end
        end else if (state_q == StRunning) begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_comb begin
        grant = '0;
        done  = '0;
        busy  = 1'b0;
        unique case (state_q)
            StIdle: begin
            end
            StRunning: begin
                busy           = 1'b1;
                grant[owner_q] = 1'b1;
                done[owner_q]  = done_hit;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_timer_arbiter.sv
// Bench for timer_arbiter: table vectors, directed corner sequences and random stimulus
// checked every cycle against a countdown reference model.
`timescale 1ns/1ps
module tb_timer_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [63:0] req_count = '0;
    logic [3:0]  grant, done;
    logic        busy;

    logic [1:0]  req4 = '0;
    logic [7:0]  cnt4 = '0;
    logic [1:0]  grant4, done4;
    logic        busy4;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: owner (-1 = idle), cycles remaining in the run including this one, pointer.
    int m_owner = -1;
    int m_rem   = 0;
    int m_ptr   = 0;

    typedef struct packed {
        logic [3:0]       req;
        logic [3:0][15:0] cnt;
        logic [3:0][7:0]  exp_done;
    } vec_t;

    vec_t tbl[6];

    always #5 clk = ~clk;

    timer_arbiter #(.NUM_REQ(4), .COUNT_W(16)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_count (req_count),
        .grant     (grant),
        .done      (done),
        .busy      (busy)
    );

    timer_arbiter #(.NUM_REQ(2), .COUNT_W(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req4),
        .req_count (cnt4),
        .grant     (grant4),
        .done      (done4),
        .busy      (busy4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit arb;
        int w;
        int c;
        if (!rst_n) begin
            m_owner = -1;
            m_rem   = 0;
            m_ptr   = 0;
            return;
        end
        arb = (m_owner < 0) || (m_rem == 1);
`ifdef TIMER_ARB_ABORT_EN
        if (m_owner >= 0 && m_rem != 1 && !req[m_owner]) arb = 1'b1;
`endif
        if (!arb) begin
            m_rem--;
            return;
        end
        w = -1;
        for (int k = 0; k < 4; k++) begin
            if (w < 0 && req[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
        end
        if (w < 0) begin
            m_owner = -1;
        end else begin
            c       = int'(req_count[w*16 +: 16]);
            m_owner = w;
            m_rem   = (c == 0) ? 1 : c;
            m_ptr   = (w + 1) % 4;
        end
    endtask

    task automatic cycle();
        logic [3:0] eg, ed;
        logic       eb;
        @(posedge clk);
        model_step();
        @(negedge clk);
        eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
        ed = (m_owner >= 0 && m_rem == 1) ? eg : 4'b0;
        eb = (m_owner >= 0);
        check("model grant/done/busy", 32'({grant, done, busy}), 32'({eg, ed, eb}));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        req4  = '0;
        cycle();
        cycle();
        check("reset outputs", 32'({grant, done, busy, grant4, done4, busy4}), 32'd0);
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic drain();
        req = '0;
        for (int c = 0; c < 40; c++) begin
            cycle();
            if (!busy) break;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_at[4];
        int rel;
        int g, dcyc, d1, g3;
        int owners[$];
        int fair_exp[4];

        tbl[0] = '{req: 4'b0001, cnt: {16'd0, 16'd0, 16'd0, 16'd5}, exp_done: {8'd0, 8'd0, 8'd0, 8'd5}};
        tbl[1] = '{req: 4'b1111, cnt: {16'd6, 16'd5, 16'd4, 16'd3},
                   exp_done: {8'd18, 8'd12, 8'd7, 8'd3}};
        tbl[2] = '{req: 4'b0001, cnt: {16'd0, 16'd0, 16'd0, 16'd0}, exp_done: {8'd0, 8'd0, 8'd0, 8'd1}};
        tbl[3] = '{req: 4'b0110, cnt: {16'd0, 16'd1, 16'd2, 16'd0}, exp_done: {8'd0, 8'd3, 8'd2, 8'd0}};
        tbl[4] = '{req: 4'b1000, cnt: {16'd1, 16'd0, 16'd0, 16'd0}, exp_done: {8'd1, 8'd0, 8'd0, 8'd0}};
        tbl[5] = '{req: 4'b1010, cnt: {16'd0, 16'd0, 16'd4, 16'd0}, exp_done: {8'd5, 8'd0, 8'd4, 8'd0}};

        // Table vectors: each requester drops req as soon as it sees its done pulse.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            req       = tbl[v].req;
            req_count = tbl[v].cnt;
            for (int i = 0; i < 4; i++) done_at[i] = 0;
            rel = 0;
            for (int c = 0; c < 100; c++) begin
                cycle();
                rel++;
                for (int i = 0; i < 4; i++) begin
                    if (done[i]) begin
                        done_at[i] = rel;
                        req[i]     = 1'b0;
                    end
                end
                if (req == '0) break;
            end
            check($sformatf("vec%0d all served", v), 32'(req), 32'd0);
            for (int i = 0; i < 4; i++) begin
                check($sformatf("vec%0d done%0d cycle", v, i), done_at[i], 32'(tbl[v].exp_done[i]));
            end
            cycle();
            check($sformatf("vec%0d idle after", v), 32'({grant, busy}), 32'd0);
        end

        // Fairness: both held high; owners must alternate.
        do_reset();
        req       = 4'b0101;
        req_count = {16'd0, 16'd3, 16'd0, 16'd2};
        fair_exp  = '{0, 2, 0, 2};
        owners.delete();
        for (int c = 0; c < 60; c++) begin
            cycle();
            for (int i = 0; i < 4; i++) if (done[i]) owners.push_back(i);
            if (owners.size() >= 4) break;
        end
        check("fair done count", owners.size(), 4);
        for (int k = 0; k < owners.size() && k < 4; k++) begin
            check($sformatf("fair owner %0d", k), owners[k], fair_exp[k]);
        end
        drain();

        // Reset mid-run, then priority returns to requester 0.
        do_reset();
        req       = 4'b0010;
        req_count = {16'd1, 16'd1, 16'd10, 16'd1};
        cycle();
        cycle();
        cycle();
        check("midrst grant before", 32'(grant), 32'b0010);
        rst_n = 1'b0;
        req   = '0;
        cycle();
        check("midrst idle", 32'({grant, done, busy}), 32'd0);
        rst_n     = 1'b1;
        req       = 4'b1111;
        req_count = {16'd1, 16'd1, 16'd1, 16'd1};
        cycle();
        check("midrst priority", 32'(grant), 32'b0001);
        drain();

        // Owner 1 drops req in its 2nd of 8 cycles with requester 3 pending.
        do_reset();
        req       = 4'b1010;
        req_count = {16'd2, 16'd0, 16'd8, 16'd0};
        cycle();
        cycle();
        check("abort grant before", 32'(grant), 32'b0010);
        req = 4'b1000;
        rel = 2;
        d1  = 0;
        g3  = 0;
        for (int c = 0; c < 30; c++) begin
            cycle();
            rel++;
            if (done[1] && d1 == 0) d1 = rel;
            if (grant[3] && g3 == 0) g3 = rel;
            if (done[3]) begin
                req = '0;
                break;
            end
        end
`ifdef TIMER_ARB_ABORT_EN
        check("abort done1 cycle", d1, 0);
        check("abort grant3 cycle", g3, 3);
`else
        check("noabort done1 cycle", d1, 8);
        check("noabort grant3 cycle", g3, 9);
`endif
        drain();

        // COUNT_W=4: full count 15 with req_count changed mid-run, then count 0.
        do_reset();
        req4 = 2'b01;
        cnt4 = 8'h0F;
        rel  = 0;
        g    = 0;
        dcyc = 0;
        for (int c = 0; c < 40; c++) begin
            cycle();
            rel++;
            if (rel == 1) cnt4 = 8'h03;
            if (grant4[0]) g++;
            if (done4[0]) begin
                dcyc = rel;
                req4 = '0;
                break;
            end
        end
        check("cw4 full done cycle", dcyc, 15);
        check("cw4 full grant cycles", g, 15);
        cycle();
        check("cw4 idle", 32'({grant4, done4, busy4}), 32'd0);
        req4 = 2'b10;
        cnt4 = 8'h00;
        rel  = 0;
        g    = 0;
        dcyc = 0;
        for (int c = 0; c < 10; c++) begin
            cycle();
            rel++;
            if (grant4[1]) g++;
            if (done4[1]) begin
                dcyc = rel;
                req4 = '0;
                break;
            end
        end
        check("cw4 zero done cycle", dcyc, 1);
        check("cw4 zero grant cycles", g, 1);

        // Random stimulus against the reference model.
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 3) == 0) req[i] = ~req[i];
                req_count[i*16 +: 16] = 16'($urandom_range(0, 6));
            end
            cycle();
        end
        rst_n = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/timer_arbiter.md
# timer_arbiter

Shares one interval counter among NUM_REQ requesters. Each requester asks for a delay of N clock cycles. The block grants the counter to one requester at a time in round-robin order, counts out that requester's delay, and pulses that requester's done bit. It sits between the protocol controllers (debounce, UART bit-timing, power-up sequencing) and replaces one private fixed-count timer per client.

## Interface
- NUM_REQ, 4: number of requesters, 2..16.
- COUNT_W, 16: width of each requested count.
- clk  input  1  clock; all logic is on its rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- req  input  NUM_REQ  per-requester request level.
- req_count  input  NUM_REQ*COUNT_W  flattened counts; requester i uses bits [i*COUNT_W +: COUNT_W].
- grant  output  NUM_REQ  one-hot (or zero); identifies the current counter owner.
- done  output  NUM_REQ  one-cycle pulse on the owner's bit when its delay completes.
- busy  output  1  high while the block is in RUNNING.

## Operation
- State machine has two states:
  - IDLE: counter free.
  - RUNNING: counter owned by the requester identified by owner.
- Registers:
  - state
  - owner index
  - latched count lcnt (COUNT_W bits)
  - timer (COUNT_W bits)
  - round-robin pointer ptr
- Arbitration:
  - Arbitration happens only in IDLE, or in the done cycle of RUNNING.
  - Winner = first i with req[i]=1, scanning ptr, ptr+1, … modulo NUM_REQ.
  - On a win: owner<=i, lcnt<=req_count[i], timer<=1, ptr<=(i+1) mod NUM_REQ, state<=RUNNING.
- Count rules:
  - A requested count of 0 is latched as 1.
  - req_count is sampled only at the win. Later changes do not affect the run in progress.
- RUNNING behaviour:
  - grant[owner]=1 and busy=1.
  - timer increments by 1 each cycle while timer != lcnt.
  - When timer == lcnt, done[owner]=1 for that cycle (combinational decode of registered state).
  - In that same done cycle, arbitration runs again. If any req is set, the next run starts with no idle gap; otherwise the block goes to IDLE.
- Handshake:
  - A requester holds req until it sees its done pulse.
  - If req[i] is still 1 in the done cycle, that is a new request. Because ptr has already advanced past i, every other pending requester is served first.
- Outputs in IDLE: grant=0, done=0, busy=0.
- Arithmetic:
  - timer never exceeds lcnt, so it cannot wrap.
  - With lcnt = 2^COUNT_W-1, the full count completes with no overflow.

## Timing
- Reset values: state=IDLE, ptr=0, owner=0, timer=0, lcnt=0; grant=0, done=0, busy=0.
- Request latency:
  - req[i] rises and is sampled in IDLE at cycle T.
  - grant[i] is high for cycles T+1..T+N.
  - done[i] is high in cycle T+N.
- Back-to-back runs:
  - A second run of M cycles starts with grant at T+N+1 and done at T+N+M.
  - Two consecutive runs therefore take exactly N+M cycles of counter time.
- Simultaneous requests in IDLE: the winner is decided by ptr alone; request arrival order within the same cycle is irrelevant.
- Reset mid-run: rst_n=0 returns the block to IDLE on the next edge. No done pulse is issued and ptr returns to 0.
- Requests arriving during a run are not sampled until the done cycle.

## Configuration
- TIMER_ARB_ABORT_EN defined:
  - In RUNNING, if req[owner]=0 in a cycle where timer != lcnt, the run is aborted and no done pulse is issued.
  - In that cycle, arbitration runs as in a done cycle, so another pending requester is granted the next cycle; otherwise the block goes to IDLE.
  - ptr has already advanced past the aborted owner.
- TIMER_ARB_ABORT_EN undefined:
  - req[owner] is ignored during RUNNING.
  - Every granted run completes and pulses done.

## Test plan
- Single request: req=4'b0001 with count 5 after reset -> grant[0] high for 5 cycles, done[0] in the 5th grant cycle, then busy=0.
- Contention: req=4'b1111 with counts 3,4,5,6, each requester dropping req on its done -> owners served in order 0,1,2,3 back-to-back with no gaps; done pulses at relative cycles 3,7,12,18.
- Fairness: req[0] held high permanently with req[2] also high -> owners alternate 0,2,0,2; requester 0 never wins twice in a row while requester 2 is waiting.
- Edge counts:
  - count 0 -> behaves exactly as count 1 (one grant cycle, done coincident).
  - COUNT_W=4 with count 15 -> done after exactly 15 cycles.
- Reset mid-run: rst_n low at the 3rd cycle of a 10-cycle run -> next cycle grant=0, busy=0, no done pulse; after release, requester 0 has priority.
- Abort (TIMER_ARB_ABORT_EN defined): owner 1 drops req at its 2nd cycle of 8 with req[3] pending -> no done[1]; grant[3] the following cycle.
- Abort (TIMER_ARB_ABORT_EN undefined): owner 1 drops req at its 2nd cycle of 8 -> run completes and done[1] pulses at cycle 8.
